// File: rtl/graphics_pkg.sv
// graphics_pkg: VGA 640x480@60 timing, frame-buffer size and the pixel word
// shared by the Graphics_ASIC pixel-sink blocks.
package graphics_pkg;
  localparam int H_VISIBLE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_VISIBLE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int FB_SIZE = H_VISIBLE * V_VISIBLE;
  localparam int COLOR_W = 3;
  localparam int ADDR_W = 19;
  localparam int PIX_W = ADDR_W + COLOR_W;
  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] color;
  } pixel_t;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous FIFO holding pixel words until a frame-buffer
// write slot is free. A push while full is ignored even if a pop happens.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 22
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  always_comb begin
    wr_d = do_push ? wr_q + AW'(1) : wr_q;
    rd_d = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/vga_pixel_sink.sv
// vga_pixel_sink: queues incoming pixels into a single-port frame buffer and
// scans it out as VGA; even clocks are read slots, odd clocks write slots.
module vga_pixel_sink
  import graphics_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int H_VISIBLE = graphics_pkg::H_VISIBLE,
  parameter int V_VISIBLE = graphics_pkg::V_VISIBLE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COLOR_W-1:0] color,
  input  logic [ADDR_W-1:0]  pixel_address,
  output logic               VGA_ready,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_wdata,
  output logic               fb_we,
  input  logic [COLOR_W-1:0] fb_rdata,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic [COLOR_W-1:0] vga_color,
  output logic               frame_start
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
  localparam logic [9:0] H_SS = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SE = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
  localparam logic [9:0] V_SS = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SE = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [ADDR_W-1:0] LINE_W = ADDR_W'(H_VISIBLE);
  localparam logic [ADDR_W-1:0] FB_LIM = ADDR_W'(H_VISIBLE * V_VISIBLE);
  pixel_t head;
  logic [CNT_W-1:0] count;
  logic full, empty, pop, vis, h_last, v_last;
  logic phase_q;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic [COLOR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] scan_addr;
  pixel_fifo #(.DEPTH(FIFO_DEPTH), .W(PIX_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(VGA_ready),
    .pop(pop),
    .din({pixel_address, color}),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  assign VGA_ready = rst & (count < CNT_W'(FIFO_DEPTH));
  assert property (@(posedge clk) full |-> count == CNT_W'(FIFO_DEPTH));
  assign vga_hsync = hs_q;
  assign vga_vsync = vs_q;
  assign vga_color = col_q;
  assign frame_start = fs_q;
  always_comb begin
    h_last = h_q == H_LAST;
    v_last = v_q == V_LAST;
    h_d = h_last ? '0 : h_q + 10'd1;
    v_d = !h_last ? v_q : v_last ? '0 : v_q + 10'd1;
    vis = (h_q < H_VIS) && (v_q < V_VIS);
    hs_d = !(h_q >= H_SS && h_q < H_SE);
    vs_d = !(v_q >= V_SS && v_q < V_SE);
    col_d = vis ? fb_rdata : '0;
    fs_d = phase_q & h_last & v_last;
    scan_addr = ADDR_W'(v_q) * LINE_W + ADDR_W'(h_q);
    pop = rst & phase_q & ~empty;
    fb_we = pop & (head.addr < FB_LIM);
    fb_wdata = fb_we ? head.color : '0;
    fb_addr = !rst ? '0 : phase_q ? (pop ? head.addr : '0) : (vis ? scan_addr : '0);
  end
  // colour and syncs of one pixel register together at the end of its write slot
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q <= 1'b0;
      h_q <= '0;
      v_q <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      col_q <= '0;
      fs_q <= 1'b0;
    end else begin
      phase_q <= ~phase_q;
      fs_q <= fs_d;
      if (phase_q) begin
        h_q <= h_d;
        v_q <= v_d;
        hs_q <= hs_d;
        vs_q <= vs_d;
        col_q <= col_d;
      end
    end
  end
endmodule
